// File: rtl/axis_uart_tx_arbiter.sv
// axis_uart_tx_arbiter: packet-level round-robin arbiter sharing one AXI-Stream FIFO/UART TX path.
// Define ARB_CHAN_HDR_EN to prefix every granted packet with a one-word channel-ID header.
module axis_uart_tx_arbiter #(
  parameter  int unsigned NUM_SRC = 4,
  parameter  int unsigned WIDTH   = 8,
  localparam int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*WIDTH-1:0] s_axis_data,
  input  logic [NUM_SRC-1:0]       s_axis_valid,
  input  logic [NUM_SRC-1:0]       s_axis_last,
  output logic [NUM_SRC-1:0]       s_axis_ready,
  output logic [WIDTH-1:0]         m_axis_data,
  output logic                     m_axis_valid,
  output logic                     m_axis_last,
  input  logic                     m_axis_ready,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1
`ifdef ARB_CHAN_HDR_EN
    , ST_HDR = 2'd2
`endif
  } state_e;

`ifdef ARB_CHAN_HDR_EN
  localparam state_e ST_GRANTED = ST_HDR;
`else
  localparam state_e ST_GRANTED = ST_PASS;
`endif

  state_e            state_q, state_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic              busy_q, busy_d;

  logic [WIDTH-1:0]  src_data [NUM_SRC];
  logic              sel_valid;
  logic              sel_last;
  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_data[g] = s_axis_data[g*WIDTH +: WIDTH];
  end

  assign sel_valid = s_axis_valid[grant_id_q];
  assign sel_last  = s_axis_last[grant_id_q];

  // Round-robin search starting just after the most recent grant.
  always_comb begin
    logic [ID_W-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = ID_W'((32'(last_grant_q) + k) % NUM_SRC);
      if (!pick_found && s_axis_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state logic: a grant is held until the packet's last beat is accepted.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_id_d   = pick_idx;
          last_grant_d = pick_idx;
          busy_d       = 1'b1;
          state_d      = ST_GRANTED;
        end
      end
`ifdef ARB_CHAN_HDR_EN
      ST_HDR: begin
        if (m_axis_ready) state_d = ST_PASS;
      end
`endif
      ST_PASS: begin
        if (sel_valid && m_axis_ready && sel_last) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Zero-latency datapath: the granted source is muxed straight through.
  always_comb begin
    m_axis_valid = 1'b0;
    m_axis_last  = 1'b0;
    m_axis_data  = '0;
    s_axis_ready = '0;
    case (state_q)
      ST_PASS: begin
        m_axis_valid             = sel_valid;
        m_axis_last              = sel_last;
        m_axis_data              = src_data[grant_id_q];
        s_axis_ready[grant_id_q] = m_axis_ready;
      end
`ifdef ARB_CHAN_HDR_EN
      ST_HDR: begin
        m_axis_valid = 1'b1;
        m_axis_data  = WIDTH'(grant_id_q);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_SRC - 1);
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// tb_axis_uart_tx_arbiter: directed and randomized checks of the packet round-robin arbiter
// against a packet-level reference model; honours ARB_CHAN_HDR_EN when defined.
module tb_axis_uart_tx_arbiter;
  localparam int unsigned N     = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned IW    = 2;
  localparam int unsigned DEPTH = 256;
`ifdef ARB_CHAN_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] s_axis_data;
  logic [N-1:0]   s_axis_valid;
  logic [N-1:0]   s_axis_last;
  logic [N-1:0]   s_axis_ready;
  logic [W-1:0]   m_axis_data;
  logic           m_axis_valid;
  logic           m_axis_last;
  logic           m_axis_ready;
  logic [IW-1:0]  grant_id;
  logic           busy;

  always #5 clk = ~clk;

  axis_uart_tx_arbiter #(.NUM_SRC(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
    .s_axis_last(s_axis_last), .s_axis_ready(s_axis_ready),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
    .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready),
    .grant_id(grant_id), .busy(busy)
  );

  int n_tests;
  int n_fail;

  // Per-source packet queues: bit 8 is the last flag, bits 7:0 the data.
  logic [8:0] sbuf [N][DEPTH];
  int         head [N];
  int         tail [N];
  int         gap_pct;
  int         beats_exp, pkts_exp, beats_in, beats_out, pkts_out;
  logic [N-1:0] hs_src;

  // Reference model: who owns the line, whether its header is still pending.
  bit            m_busy;
  bit            m_hdr;
  logic [IW-1:0] m_gid;
  logic [IW-1:0] m_ptr;

  int  ng, idle, b0;
  bit  prev_busy;
  int  gl [8];
  int  exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  bit  bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_hdr  = 1'b0;
    m_gid  = '0;
    m_ptr  = IW'(N - 1);
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < int'(N); i++) if (head[i] != tail[i]) e = 1'b0;
    return e;
  endfunction

  task automatic push(input int s, input logic [7:0] d, input bit last);
    sbuf[s][tail[s]] = {last, d};
    tail[s]++;
    beats_exp++;
    if (last) pkts_exp++;
  endtask

  task automatic clear_q();
    for (int i = 0; i < int'(N); i++) begin
      for (int j = head[i]; j < tail[i]; j++) begin
        beats_exp--;
        if (sbuf[i][j][8]) pkts_exp--;
      end
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < int'(N); i++) begin
      if (head[i] != tail[i] && int'($urandom_range(99)) >= gap_pct) begin
        s_axis_valid[i]       = 1'b1;
        s_axis_last[i]        = sbuf[i][head[i]][8];
        s_axis_data[i*W +: W] = sbuf[i][head[i]][7:0];
      end else begin
        s_axis_valid[i]       = 1'b0;
        s_axis_last[i]        = 1'b0;
        s_axis_data[i*W +: W] = '0;
      end
    end
  endtask

  // Expected outputs follow from who owns the line and the current inputs.
  task automatic check_cycle();
    logic [W-1:0] e_data;
    logic         e_valid;
    logic         e_last;
    logic [N-1:0] e_ready;
    e_data  = '0;
    e_valid = 1'b0;
    e_last  = 1'b0;
    e_ready = '0;
    if (m_busy && m_hdr) begin
      e_valid = 1'b1;
      e_data  = W'(m_gid);
    end else if (m_busy) begin
      e_valid        = s_axis_valid[m_gid];
      e_last         = s_axis_last[m_gid];
      e_data         = s_axis_data[32'(m_gid)*W +: W];
      e_ready[m_gid] = m_axis_ready;
    end
    chk("m_valid",  32'(m_axis_valid), 32'(e_valid));
    chk("m_last",   32'(m_axis_last),  32'(e_last));
    chk("m_data",   32'(m_axis_data),  32'(e_data));
    chk("s_ready",  32'(s_axis_ready), 32'(e_ready));
    chk("busy",     32'(busy),         32'(m_busy));
    chk("grant_id", 32'(grant_id),     32'(m_gid));
    hs_src = s_axis_valid & s_axis_ready;
    if (m_axis_valid && m_axis_ready) begin
      if (!(m_busy && m_hdr)) beats_out++;
      if (m_axis_last) pkts_out++;
    end
  endtask

  task automatic model_step();
    logic [IW-1:0] c;
    bit found;
    found = 1'b0;
    if (!m_busy) begin
      for (int k = 1; k <= int'(N); k++) begin
        c = IW'((32'(m_ptr) + 32'(k)) % N);
        if (!found && s_axis_valid[c]) begin
          found  = 1'b1;
          m_gid  = c;
          m_ptr  = c;
          m_busy = 1'b1;
          m_hdr  = HDR_EN;
        end
      end
    end else if (m_hdr) begin
      if (m_axis_ready) m_hdr = 1'b0;
    end else if (s_axis_valid[m_gid] && m_axis_ready && s_axis_last[m_gid]) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    if (rst) model_step();
    for (int i = 0; i < int'(N); i++) begin
      if (hs_src[i] && head[i] != tail[i]) begin
        head[i]++;
        beats_in++;
      end
    end
    #1;
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    repeat (2) cycle();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; gap_pct = 0;
    beats_exp = 0; pkts_exp = 0; beats_in = 0; beats_out = 0; pkts_out = 0;
    for (int i = 0; i < int'(N); i++) begin head[i] = 0; tail[i] = 0; end
    hs_src = '0;
    rst = 1'b0;
    s_axis_data = '0; s_axis_valid = '0; s_axis_last = '0; m_axis_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_m_valid", 32'(m_axis_valid), 32'd0);
    chk("rst_s_ready", 32'(s_axis_ready), 32'd0);
    repeat (2) cycle();
    rst = 1'b1;
    #1;
    repeat (3) cycle();
    chk("idle_m_valid", 32'(m_axis_valid), 32'd0);
    chk("idle_s_ready", 32'(s_axis_ready), 32'd0);
    chk("idle_busy",    32'(busy),         32'd0);
    chk("idle_grant",   32'(grant_id),     32'd0);

`ifndef ARB_CHAN_HDR_EN
    // Three-beat packet from source 2 passes straight through.
    m_axis_ready = 1'b1;
    push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
    drive(); #1;
    cycle();
    chk("ss_grant", 32'(grant_id), 32'd2);
    chk("ss_busy",  32'(busy),     32'd1);
    chk("ss_d0",    32'(m_axis_data), 32'h41);
    cycle();
    chk("ss_d1",    32'(m_axis_data), 32'h42);
    chk("ss_l1",    32'(m_axis_last), 32'd0);
    cycle();
    chk("ss_d2",    32'(m_axis_data),  32'h43);
    chk("ss_l2",    32'(m_axis_last),  32'd1);
    chk("ss_v2",    32'(m_axis_valid), 32'd1);
    cycle();
    chk("ss_busy_fall",  32'(busy),     32'd0);
    chk("ss_grant_hold", 32'(grant_id), 32'd2);
`else
    // Single-beat packet from source 3 gets its channel-ID header first.
    m_axis_ready = 1'b1;
    push(3, 8'h55, 1'b1);
    drive(); #1;
    cycle();
    chk("hdr_valid", 32'(m_axis_valid), 32'd1);
    chk("hdr_data",  32'(m_axis_data),  32'h03);
    chk("hdr_last",  32'(m_axis_last),  32'd0);
    chk("hdr_grant", 32'(grant_id),     32'd3);
    cycle();
    chk("hdr_pay_data", 32'(m_axis_data),  32'h55);
    chk("hdr_pay_last", 32'(m_axis_last),  32'd1);
    chk("hdr_pay_valid", 32'(m_axis_valid), 32'd1);
    cycle();
    chk("hdr_busy_fall", 32'(busy), 32'd0);
`endif

    // Fairness: every source holds two 2-beat packets.
    do_reset();
    clear_q();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < int'(N); s++) begin
        push(s, 8'($urandom), 1'b0);
        push(s, 8'($urandom), 1'b1);
      end
    m_axis_ready = 1'b1;
    drive(); #1;
    ng = 0; idle = 0; prev_busy = 1'b0;
    for (int c = 0; c < 200; c++) begin
      cycle();
      if (busy && !prev_busy && ng < 8) begin
        gl[ng] = int'(grant_id);
        ng++;
      end else if (!busy && ng > 0 && !all_empty()) begin
        idle++;
      end
      prev_busy = busy;
      if (!busy && all_empty()) break;
    end
    chk("fair_ngrants", 32'(ng), 32'd8);
    for (int i = 0; i < 8; i++) chk("fair_order", 32'(gl[i]), 32'(exp_order[i]));
    chk("fair_bubbles", 32'(idle), 32'd7);

    // Backpressure on source 1.
    clear_q();
    b0 = beats_out;
    push(1, 8'hA0, 1'b0); push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1);
    m_axis_ready = 1'b1;
    drive(); #1;
    cycle();
    if (HDR_EN) cycle();
    for (int c = 0; c < 30; c++) begin
      m_axis_ready = (c < 4) ? bp_pat[c] : 1'b1;
      #1;
      chk("bp_ready_mirror", 32'(s_axis_ready), 32'({2'b00, m_axis_ready, 1'b0}));
      cycle();
      if (!busy && all_empty()) break;
    end
    chk("bp_beats_out", 32'(beats_out - b0), 32'd4);

    // Reset in the middle of a source-0 packet.
    clear_q();
    b0 = beats_in;
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1);
    m_axis_ready = 1'b1;
    drive(); #1;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (beats_in > b0) break;
    end
    chk("mr_one_beat", 32'(beats_in - b0), 32'd1);
    rst = 1'b0;
    #1;
    chk("mr_m_valid", 32'(m_axis_valid), 32'd0);
    chk("mr_s_ready", 32'(s_axis_ready), 32'd0);
    chk("mr_busy",    32'(busy),         32'd0);
    model_reset();
    clear_q();
    push(3, 8'h77, 1'b1);
    drive(); #1;
    repeat (2) cycle();
    rst = 1'b1;
    #1;
    cycle();
    chk("mr_grant_src3", 32'(grant_id), 32'd3);
    chk("mr_busy_again", 32'(busy),     32'd1);
    for (int c = 0; c < 20; c++) begin
      if (!busy && all_empty()) break;
      cycle();
    end

    // Randomized traffic with gaps and downstream backpressure.
    do_reset();
    clear_q();
    gap_pct = 20;
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < int'(N); s++) begin
        if (head[s] == tail[s] && $urandom_range(3) == 0) begin
          int len;
          head[s] = 0;
          tail[s] = 0;
          len = int'($urandom_range(4, 1));
          for (int b = 0; b < len; b++) push(s, 8'($urandom), b == len - 1);
        end
      end
      m_axis_ready = ($urandom_range(99) < 70);
      drive(); #1;
      cycle();
    end
    gap_pct = 0;
    m_axis_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!busy && all_empty()) break;
      cycle();
    end
    chk("drain_done", 32'(all_empty() && !busy), 32'd1);
    chk("beats_out", 32'(beats_out), 32'(beats_exp));
    chk("pkts_out",  32'(pkts_out),  32'(pkts_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_uart_tx_arbiter.md
Name: axis_uart_tx_arbiter

Overview:
- Packet-level round-robin arbiter sharing one AXI-Stream UART transmit path (FIFO + UART TX) between NUM_SRC AXI-Stream requesters.
- A grant is held for a whole packet, from the first beat through the beat with s_axis_last, so packets are never interleaved on the UART line.
- Sits directly upstream of axis_fifo_uart_tx; the m_axis_* ports connect to its s_axis_* ports.

Parameters:
- NUM_SRC, 4, number of requesting AXI-Stream sources (2..8).
- WIDTH, 8, data width per beat; must match the downstream FIFO/UART word length.
- ID_W, $clog2(NUM_SRC), width of grant_id (localparam, derived).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous reset, active-low.
- s_axis_data  input  NUM_SRC*WIDTH  packed source data; source i occupies bits [i*WIDTH +: WIDTH].
- s_axis_valid  input  NUM_SRC  per-source valid.
- s_axis_last  input  NUM_SRC  per-source end-of-packet.
- s_axis_ready  output  NUM_SRC  per-source ready.
- m_axis_data  output  WIDTH  to FIFO/UART path.
- m_axis_valid  output  1  to FIFO/UART path.
- m_axis_last  output  1  to FIFO/UART path.
- m_axis_ready  input  1  from FIFO/UART path (its s_axis_ready).
- grant_id  output  ID_W  index of the current or most recent grant holder.
- busy  output  1  high while a packet is granted (states HDR/PASS).

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous, active-low, on rst.
- Reset values:
  - state = IDLE, last_grant = NUM_SRC-1 (source 0 wins first), grant_id = 0, busy = 0.
  - m_axis_valid = 0, m_axis_last = 0, m_axis_data = 0, s_axis_ready = all 0.
- State IDLE:
  - m_axis_valid = 0 and s_axis_ready = all 0.
  - If any s_axis_valid bit is high at the clock edge, pick the first asserted source searching last_grant+1, last_grant+2, … modulo NUM_SRC.
  - Register that index into grant_id and last_grant, set busy = 1, and go to PASS (HDR if the option is enabled).
- State PASS (combinational pass-through, zero added latency):
  - m_axis_data/valid/last = s_axis_data/valid/last of source grant_id.
  - s_axis_ready[grant_id] = m_axis_ready; every other ready bit = 0.
  - On m_axis_valid && m_axis_ready && m_axis_last, go to IDLE and set busy = 0. grant_id holds its value.
- Arbitration latency: one cycle in IDLE between packets, so back-to-back packets cost one bubble. This is accepted.
- Round robin: the pointer advances only when a grant is issued. A lone requester is granted repeatedly. With all sources requesting, the order is 0, 1, 2, 3, 0, …
- Single-beat packet (first beat has last = 1): PASS lasts one transfer, then IDLE.
- Granted source drops valid mid-packet: the grant stays locked with m_axis_valid = 0. There is no timeout, and other sources keep waiting.
- Downstream backpressure (m_axis_ready = 0): the granted source sees ready = 0. The arbiter holds no data of its own, so nothing is lost.
- Requester deasserts valid between the IDLE sample and PASS: the grant is still issued, and the arbiter waits in PASS for that source's packet.
- Reset asserted mid-packet: go to IDLE immediately; m_axis_valid and all ready bits drop asynchronously. A partial packet already in the FIFO is the system's responsibility.
- Non-granted sources are never given ready = 1.

Optional Feature:
- Macro: ARB_CHAN_HDR_EN.
- Defined:
  - Each grant passes through state HDR before PASS.
  - In HDR: m_axis_valid = 1, m_axis_last = 0, m_axis_data = grant_id zero-extended to WIDTH, s_axis_ready = all 0.
  - On m_axis_ready, go to PASS.
  - Every packet on the UART is prefixed with one channel-ID byte.
  - Reset during HDR returns to IDLE.
- Undefined: the HDR state does not exist, and IDLE goes directly to PASS.

Test Plan:
- Reset then idle: rst low then high with no valid → m_axis_valid = 0, s_axis_ready = 4'b0000, busy = 0, grant_id = 0.
- Single source: src2 sends 3 beats 0x41, 0x42, 0x43 (last on 0x43) with m_axis_ready = 1 → m_axis sees 0x41, 0x42, 0x43 on consecutive cycles with m_axis_last on the 3rd; grant_id = 2; busy falls the cycle after the last beat.
- Fairness: all 4 sources hold valid with 2-beat packets, ready = 1 → grant order 0, 1, 2, 3, 0; exactly one idle cycle between packets; no interleaving.
- Backpressure: src1 granted, m_axis_ready toggles 1, 0, 0, 1 → s_axis_ready[1] mirrors m_axis_ready; beat count out equals beats in (4 → 4); other ready bits stay 0.
- Mid-packet reset: src0 granted after 1 of 3 beats, rst pulsed low → m_axis_valid = 0 immediately; after release, src3 requesting is granted first (pointer reset, src0 not requesting).
- Header option (ARB_CHAN_HDR_EN defined): src3 sends 0x55 (last) → m_axis sequence 0x03 (last = 0), then 0x55 (last = 1).
